usb_rx_unstuff: RTL and testbench

USB_RX_UNSTUFF -- requirements
Module: usb_rx_unstuff

---
 rtl/usb_rx_pkg.sv | 23 ++
 rtl/usb_nrzi_dec.sv | 37 +++
 rtl/usb_rx_unstuff.sv | 187 ++++++++++++++++++
 tb/tb_usb_rx_unstuff.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared line-state/FSM types and constants for the USB receive unstuffer
package usb_rx_pkg;

   // Encoded directly as {dp, dm}
   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_K   = 2'b01,
      LS_J   = 2'b10,
      LS_SE1 = 2'b11
   } line_state_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP
   } rx_state_e;

   localparam logic [7:0] SYNC_PATTERN    = 8'b1000_0000;
   localparam int         STUFF_LIMIT_DEF = 6;
   localparam int         MIN_SE0_DEF     = 2;

endpackage

// File: rtl/usb_nrzi_dec.sv
// rtl/usb_nrzi_dec.sv - line-state decode and NRZI bit recovery with previous-level register
module usb_nrzi_dec
   import usb_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        dp_i,
   input  logic        dm_i,
   input  logic        force_j_i,
   output line_state_e ls_o,
   output logic        bit_o
);

   // prev level: 1 = J, 0 = K
   logic prev_q, prev_d;

   assign ls_o  = line_state_e'({dp_i, dm_i});
   assign bit_o = (dp_i == prev_q);

   always_comb begin
      prev_d = prev_q;
      if (force_j_i) begin
         prev_d = 1'b1;
      end else if (ls_o == LS_J || ls_o == LS_K) begin
         prev_d = dp_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/usb_rx_unstuff.sv
// rtl/usb_rx_unstuff.sv - USB receive FSM: SYNC, bit unstuffing, EOP detection
// USB_SYNC_STRIP_EN: check and strip SYNC; otherwise SYNC bits pass through unchecked.
module usb_rx_unstuff
   import usb_rx_pkg::*;
#(
   parameter int STUFF_LIMIT = STUFF_LIMIT_DEF,
   parameter int MIN_SE0     = MIN_SE0_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic dp,
   input  logic dm,
   output logic dout,
   output logic dout_valid,
   output logic pkt_start,
   output logic pkt_end,
   output logic rx_err,
   output logic active
);

   localparam int OW = $clog2(STUFF_LIMIT + 1);
   localparam int SW = (MIN_SE0 < 2) ? 1 : $clog2(MIN_SE0 + 1);
   localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);
   localparam logic [SW-1:0] SE0_MAX  = SW'(MIN_SE0);

   line_state_e ls;
   logic        dbit;
   logic        force_j;

   rx_state_e   state_q, state_d;
   logic [OW-1:0] ones_q, ones_d;
   logic [2:0]    sync_q, sync_d;
   logic [SW-1:0] se0_q, se0_d;
   logic dout_d, valid_d, start_d, end_d, err_d;
`ifdef USB_SYNC_STRIP_EN
   logic first_q, first_d;
`endif

   usb_nrzi_dec u_dec (
      .clk       (clk),
      .rst       (rst),
      .dp_i      (dp),
      .dm_i      (dm),
      .force_j_i (force_j),
      .ls_o      (ls),
      .bit_o     (dbit)
   );

   // Previous level is held at J whenever the FSM rests in IDLE
   assign force_j = (state_d == ST_IDLE);

   always_comb begin
      state_d = state_q;
      ones_d  = ones_q;
      sync_d  = sync_q;
      se0_d   = se0_q;
      dout_d  = 1'b0;
      valid_d = 1'b0;
      start_d = 1'b0;
      end_d   = 1'b0;
      err_d   = 1'b0;
`ifdef USB_SYNC_STRIP_EN
      first_d = first_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (ls == LS_K) begin
               state_d = ST_SYNC;
               sync_d  = 3'd1;
`ifndef USB_SYNC_STRIP_EN
               dout_d  = dbit;
               valid_d = 1'b1;
               start_d = 1'b1;
`endif
            end
         end
         ST_SYNC: begin
            if (ls == LS_SE1) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (ls == LS_SE0) begin
`ifdef USB_SYNC_STRIP_EN
               err_d   = 1'b1;
               state_d = ST_IDLE;
`else
               state_d = ST_EOP;
               se0_d   = SW'(1);
`endif
            end else begin
`ifdef USB_SYNC_STRIP_EN
               if (dbit != SYNC_PATTERN[sync_q]) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else if (sync_q == 3'd7) begin
                  state_d = ST_DATA;
                  ones_d  = '0;
                  first_d = 1'b1;
               end else begin
                  sync_d = sync_q + 3'd1;
               end
`else
               dout_d  = dbit;
               valid_d = 1'b1;
               if (sync_q == 3'd7) begin
                  state_d = ST_DATA;
                  ones_d  = '0;
               end else begin
                  sync_d = sync_q + 3'd1;
               end
`endif
            end
         end
         ST_DATA: begin
            // SE0 wins over a pending stuffed bit
            if (ls == LS_SE1) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (ls == LS_SE0) begin
               state_d = ST_EOP;
               se0_d   = SW'(1);
            end else if (ones_q == ONES_MAX) begin
               if (dbit) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ones_d = '0;
               end
            end else begin
               dout_d  = dbit;
               valid_d = 1'b1;
               ones_d  = dbit ? ones_q + 1'b1 : '0;
`ifdef USB_SYNC_STRIP_EN
               start_d = first_q;
               first_d = 1'b0;
`endif
            end
         end
         ST_EOP: begin
            if (ls == LS_SE0) begin
               if (se0_q < SE0_MAX) se0_d = se0_q + 1'b1;
            end else begin
               state_d = ST_IDLE;
               if (ls == LS_J && se0_q >= SE0_MAX) end_d = 1'b1;
               else                                  err_d = 1'b1;
            end
         end
      endcase
      if (state_d == ST_IDLE) begin
         ones_d = '0;
         sync_d = '0;
         se0_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ones_q     <= '0;
         sync_q     <= '0;
         se0_q      <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         pkt_start  <= 1'b0;
         pkt_end    <= 1'b0;
         rx_err     <= 1'b0;
         active     <= 1'b0;
`ifdef USB_SYNC_STRIP_EN
         first_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ones_q     <= ones_d;
         sync_q     <= sync_d;
         se0_q      <= se0_d;
         dout       <= dout_d;
         dout_valid <= valid_d;
         pkt_start  <= start_d;
         pkt_end    <= end_d;
         rx_err     <= err_d;
         active     <= (state_d != ST_IDLE);
`ifdef USB_SYNC_STRIP_EN
         first_q    <= first_d;
`endif
      end
   end

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// tb/tb_usb_rx_unstuff.sv - self-checking bench: packet builder with per-sample expectations
module tb_usb_rx_unstuff;

   localparam int LIMIT   = 6;
   localparam int MIN_EOP = 2;
`ifdef USB_SYNC_STRIP_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dp  = 1'b1;
   logic dm  = 1'b0;
   logic dout, dout_valid, pkt_start, pkt_end, rx_err, active;

   usb_rx_unstuff #(.STUFF_LIMIT(LIMIT), .MIN_SE0(MIN_EOP)) dut (
      .clk        (clk),
      .rst        (rst),
      .dp         (dp),
      .dm         (dm),
      .dout       (dout),
      .dout_valid (dout_valid),
      .pkt_start  (pkt_start),
      .pkt_end    (pkt_end),
      .rx_err     (rx_err),
      .active     (active)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic dp, dm, dout, valid, start, pend, err, act;
   } smp_t;

   smp_t q[$];
   smp_t e;
   bit   chk_en = 1'b0;
   int   n_cmp = 0, n_bad = 0, sidx = 0;
   logic cap[$];
   int   end_cnt = 0, err_cnt = 0;
   logic lvl = 1'b1;
   int   ones = 0;
   bit   first = 1'b0, aborted = 1'b0;

   // Every-cycle check of DUT outputs against the expectation for the sample driven last
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         n_cmp++;
         if (dout_valid !== e.valid || (e.valid && dout !== e.dout) || pkt_start !== e.start ||
             pkt_end !== e.pend || rx_err !== e.err || active !== e.act) begin
            n_bad++;
            $display("FAIL sample %0d: got v=%b d=%b st=%b end=%b err=%b act=%b, need v=%b d=%b st=%b end=%b err=%b act=%b",
                     sidx, dout_valid, dout, pkt_start, pkt_end, rx_err, active,
                     e.valid, e.dout, e.start, e.pend, e.err, e.act);
         end
      end
      if (dout_valid === 1'b1) cap.push_back(dout);
      if (pkt_end === 1'b1) end_cnt++;
      if (rx_err === 1'b1) err_cnt++;
   end

   task automatic chk(input string name, input int got, input int need);
      n_cmp++;
      if (got != need) begin
         n_bad++;
         $display("FAIL %s: got %0d, need %0d", name, got, need);
      end
   endtask

   function automatic int cap_last(input int n);
      int r = 0;
      if (cap.size() < n) return -1;
      for (int i = 0; i < n; i++) r |= int'(cap[cap.size() - n + i]) << i;
      return r;
   endfunction

   task automatic push(input logic p, m, d, v, s, pe, er, a);
      smp_t t;
      t.dp = p; t.dm = m; t.dout = d; t.valid = v;
      t.start = s; t.pend = pe; t.err = er; t.act = a;
      q.push_back(t);
   endtask

   task automatic idle(input int n);
      repeat (n) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      lvl = 1'b1;
   endtask

   // NRZI: a 0 toggles the line level, a 1 keeps it
   task automatic line_bit(input logic b, input logic d, input logic v, input logic s);
      if (!b) lvl = ~lvl;
      push(lvl, ~lvl, d, v, s, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic send_sync(input int corrupt);
      aborted = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic b;
         b = (i == 7) ? 1'b1 : 1'b0;
         if (i == corrupt) b = ~b;
         if (STRIP && i == corrupt) begin
            if (!b) lvl = ~lvl;
            push(lvl, ~lvl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            aborted = 1'b1;
            return;
         end
         line_bit(b, b, !STRIP, !STRIP && i == 0);
      end
      ones  = 0;
      first = 1'b1;
   endtask

   // A stuffed 0 is inserted only ahead of the next data bit, so a run of six 1s may meet SE0 directly
   task automatic send_data(input logic b);
      if (ones == LIMIT) begin
         line_bit(1'b0, 1'b0, 1'b0, 1'b0);
         ones = 0;
      end
      line_bit(b, b, 1'b1, STRIP && first);
      first = 1'b0;
      ones  = b ? ones + 1 : 0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_data(v[i]);
   endtask

   task automatic stuff_err();
      while (ones < LIMIT) send_data(1'b1);
      push(lvl, ~lvl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic se1_err();
      push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic eop(input int n, input bit end_j);
      repeat (n) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (end_j) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, n >= MIN_EOP, n < MIN_EOP, 1'b0);
      else       push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      lvl = 1'b1;
   endtask

   task automatic play();
      foreach (q[i]) begin
         @(negedge clk);
         dp = q[i].dp; dm = q[i].dm; e = q[i]; chk_en = 1'b1; sidx++;
      end
      @(negedge clk);
      chk_en = 1'b0;
      dp = 1'b1; dm = 1'b0;
      q.delete();
   endtask

   task automatic begin_test();
      cap.delete();
      end_cnt = 0;
      err_cnt = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, need completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, len;
      #2 rst = 1'b0;
      #1 chk("reset_outputs", int'({dout, dout_valid, pkt_start, pkt_end, rx_err, active}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      begin_test(); idle(3); send_sync(-1); send_byte(8'hA5); eop(2, 1'b1); idle(2); play();
      chk("a5_valid_count", cap.size(), STRIP ? 8 : 16);
      chk("a5_byte", cap_last(8), 'hA5);
      chk("a5_pkt_end", end_cnt, 1);
      chk("a5_rx_err", err_cnt, 0);

      begin_test(); idle(2); send_sync(-1); repeat (6) send_data(1'b1); send_data(1'b0);
      eop(2, 1'b1); idle(2); play();
      chk("stuff_valid_count", cap.size(), STRIP ? 7 : 15);
      chk("stuff_bits", cap_last(7), 'h3F);
      chk("stuff_pkt_end", end_cnt, 1);

      begin_test(); idle(2); send_sync(-1); stuff_err(); idle(2); play();
      chk("seven_ones_err", err_cnt, 1);
      chk("seven_ones_end", end_cnt, 0);
      chk("seven_ones_active", int'(active), 0);

      begin_test(); idle(2); send_sync(3);
      if (!aborted) begin send_data(1'b1); send_data(1'b0); eop(2, 1'b1); end
      idle(2); play();
      chk("sync_bad_err", err_cnt, STRIP ? 1 : 0);
      chk("sync_bad_valid", cap.size(), STRIP ? 0 : 10);
      chk("sync_bad_active", int'(active), 0);

      begin_test(); idle(2); send_sync(-1); send_byte(8'h3C); eop(1, 1'b1); idle(2); play();
      chk("short_eop_err", err_cnt, 1);
      chk("short_eop_end", end_cnt, 0);
      begin_test(); idle(2); send_sync(-1); send_byte(8'h3C); eop(3, 1'b1); idle(2); play();
      chk("long_eop_end", end_cnt, 1);
      chk("long_eop_err", err_cnt, 0);

      begin_test(); idle(2); send_sync(-1); repeat (6) send_data(1'b1); eop(2, 1'b1); idle(2); play();
      chk("stuff_at_se0_end", end_cnt, 1);
      chk("stuff_at_se0_err", err_cnt, 0);

      begin_test(); idle(2); send_sync(-1); send_byte(8'h5A); play();
      #2 rst = 1'b0;
      #1 chk("rst_mid_outputs", int'({dout, dout_valid, pkt_start, pkt_end, rx_err, active}), 0);
      @(posedge clk); #1;
      chk("rst_hold_outputs", int'({dout, dout_valid, pkt_start, pkt_end, rx_err, active}), 0);
      @(negedge clk); rst = 1'b1; lvl = 1'b1;
      chk("rst_no_end", end_cnt, 0);
      chk("rst_no_err", err_cnt, 0);
      begin_test(); idle(2); send_sync(-1); send_byte(8'hC3); eop(2, 1'b1); idle(2); play();
      chk("post_rst_byte", cap_last(8), 'hC3);
      chk("post_rst_end", end_cnt, 1);

      repeat (150) begin
         idle($urandom_range(1, 3));
         if ($urandom_range(0, 4) == 0) begin
            logic x;
            x = 1'($urandom_range(0, 1));
            push(x, x, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(1);
         end
         kind = $urandom_range(0, 6);
         send_sync((kind == 5) ? $urandom_range(1, 7) : -1);
         if (!aborted) begin
            len = $urandom_range(1, 20);
            repeat (len) send_data($urandom_range(0, 3) != 0);
            case (kind)
               3:       stuff_err();
               4:       se1_err();
               6:       eop($urandom_range(1, 3), 1'b0);
               default: eop($urandom_range(1, 4), 1'b1);
            endcase
         end
         idle(2);
         play();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
